// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - burst reader that drains an upstream FIFO into a valid/ready stream
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   fifo_empty       upstream FIFO empty flag
//   fifo_prog_empty  upstream programmable-empty flag (low: at least BURST_LEN words stored)
//   fifo_data        upstream read data, valid the cycle after fifo_rd_en
//   fifo_rd_en       upstream read strobe
//   m_valid, m_ready output handshake
//   m_data, m_last   output word and end-of-burst marker
//   busy             high whenever the FSM is not idle
module fifo_burst_reader #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic             fifo_prog_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy
);

  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state_q;
  logic [7:0]       idle_cnt_q;
  logic [CW-1:0]    rd_left_q;
  logic             inflight_q;
  logic             inflight_last_q;
  logic [WIDTH-1:0] buf_data_q [2];
  logic [1:0]       buf_last_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;

  logic       accept;
  logic       reading;
  logic       last_read;
  logic [1:0] occ_after;

  assign m_valid   = (count_q != 2'd0);
  assign accept    = m_valid & m_ready;
  assign reading   = (state_q == S_BURST) || (state_q == S_FLUSH);
  assign last_read = (rd_left_q == CW'(1));

  // Occupancy net of a word leaving this cycle, so a steady stream can keep
  // one read per cycle while the 2-entry buffer can never overflow.
  assign occ_after = count_q - {1'b0, accept};

  assign fifo_rd_en = reading && !fifo_empty && (rd_left_q != '0) &&
                      ((occ_after + {1'b0, inflight_q}) < 2'd2);

  assign count_d = count_q + {1'b0, inflight_q} - {1'b0, accept};

  assign m_data = buf_data_q[rd_ptr_q];
  assign m_last = m_valid & buf_last_q[rd_ptr_q];
  assign busy   = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      idle_cnt_q      <= '0;
      rd_left_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_data_q[0]   <= '0;
      buf_data_q[1]   <= '0;
      buf_last_q      <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      // Standard-mode FIFO: data arrives one cycle after the strobe, so the
      // last-word tag travels alongside the in-flight flag.
      inflight_q      <= fifo_rd_en;
      inflight_last_q <= fifo_rd_en & last_read;

      if (inflight_q) begin
        buf_data_q[wr_ptr_q] <= fifo_data;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (accept) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;

      case (state_q)
        S_IDLE: begin
          if (!fifo_prog_empty) begin
            state_q    <= S_BURST;
            rd_left_q  <= CW'(BURST_LEN);
            idle_cnt_q <= '0;
          end else if (!fifo_empty) begin
            if (idle_cnt_q == 8'(TIMEOUT - 1)) begin
              state_q    <= S_FLUSH;
              rd_left_q  <= CW'(1);
              idle_cnt_q <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 8'd1;
            end
          end else begin
            idle_cnt_q <= '0;
          end
        end
        S_BURST, S_FLUSH: begin
          // An empty upstream simply withholds fifo_rd_en; the burst stays open.
          if (fifo_rd_en) begin
            rd_left_q <= rd_left_q - CW'(1);
            if (last_read) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (accept && m_last) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

  localparam int WIDTH     = 8;
  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fifo_empty = 1'b1;
  logic             fifo_prog_empty = 1'b1;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .WIDTH    (WIDTH),
    .BURST_LEN(BURST_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_prog_empty(fifo_prog_empty),
    .fifo_data      (fifo_data),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;

  // Upstream FIFO model and observation records
  logic [WIDTH-1:0] up_q[$];
  logic [WIDTH-1:0] obs_d[$];
  bit               obs_l[$];
  int               rd_cycles[$];
  bit               force_prog_low = 1'b0;
  bit               rd_s = 1'b0;
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             prev_last = 1'b0;
  int               outstanding = 0;
  int               valid_cycles = 0;
  int               cyc_n = 0;

  typedef struct {
    int nwords;
    int exp_first_rd;
    int exp_rd_window;
    int exp_last_mask;
  } vec_t;

  vec_t vecs[6];

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_flags();
    fifo_empty      = (up_q.size() == 0);
    fifo_prog_empty = (up_q.size() < BURST_LEN) && !force_prog_low;
  endtask

  // One clock cycle: sample at the falling edge, then update the upstream model after the rising edge.
  task automatic step();
    bit acc;
    @(negedge clk);
    acc = m_valid & m_ready;
    if (prev_stall) begin
      check_eq("hold_valid", int'(m_valid), 1);
      check_eq("hold_data", int'(m_data), int'(prev_data));
      check_eq("hold_last", int'(m_last), int'(prev_last));
    end
    if (fifo_rd_en) begin
      check_eq("rd_while_empty", int'(up_q.size() > 0), 1);
      rd_cycles.push_back(cyc_n);
      outstanding++;
    end
    if (m_valid) valid_cycles++;
    if (acc) begin
      obs_d.push_back(m_data);
      obs_l.push_back(m_last);
      outstanding--;
    end
    if (fifo_rd_en) check_eq("outstanding_le2", int'(outstanding <= 2), 1);
    prev_stall = m_valid & ~m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    rd_s       = fifo_rd_en;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rd_s && up_q.size() > 0) fifo_data = up_q.pop_front();
    set_flags();
  endtask

  task automatic clear_obs();
    obs_d.delete();
    obs_l.delete();
    rd_cycles.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_rd_en"}, int'(fifo_rd_en), 0);
    check_eq({tag, "_m_valid"}, int'(m_valid), 0);
    check_eq({tag, "_m_data"}, int'(m_data), 0);
    check_eq({tag, "_m_last"}, int'(m_last), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
  endtask

  function automatic int last_mask();
    int m = 0;
    foreach (obs_l[j]) if (obs_l[j] && j < 31) m |= (1 << j);
    return m;
  endfunction

  initial begin
    logic [WIDTH-1:0] exp_w[$];
    logic [WIDTH-1:0] w;
    int t, base, first, cnt, ok, sent, nd, nl;

    vecs[0] = '{nwords: 1, exp_first_rd: 16, exp_rd_window: 1, exp_last_mask: 'h01};
    vecs[1] = '{nwords: 4, exp_first_rd: 1,  exp_rd_window: 4, exp_last_mask: 'h08};
    vecs[2] = '{nwords: 6, exp_first_rd: 1,  exp_rd_window: 4, exp_last_mask: 'h38};
    vecs[3] = '{nwords: 3, exp_first_rd: 16, exp_rd_window: 1, exp_last_mask: 'h07};
    vecs[4] = '{nwords: 8, exp_first_rd: 1,  exp_rd_window: 4, exp_last_mask: 'h88};
    vecs[5] = '{nwords: 5, exp_first_rd: 1,  exp_rd_window: 4, exp_last_mask: 'h18};

    // Reset state
    set_flags();
    #2;
    check_outputs_zero("reset");
    repeat (3) step();
    check_outputs_zero("reset_hold");
    rst_n = 1'b1;
    step();

    // Table-driven bursts and flushes with m_ready held high
    for (int i = 0; i < 6; i++) begin
      clear_obs();
      exp_w.delete();
      m_ready = 1'b1;
      for (int k = 0; k < vecs[i].nwords; k++) begin
        w = WIDTH'($urandom);
        up_q.push_back(w);
        exp_w.push_back(w);
      end
      set_flags();
      base = cyc_n;
      t = 0;
      while (obs_d.size() < vecs[i].nwords && t < 300) begin
        step();
        t++;
      end
      check_eq($sformatf("vec%0d_words_out", i), obs_d.size(), vecs[i].nwords);
      first = (rd_cycles.size() > 0) ? rd_cycles[0] - base : -1;
      check_eq($sformatf("vec%0d_first_rd", i), first, vecs[i].exp_first_rd);
      cnt = 0;
      foreach (rd_cycles[j]) if (rd_cycles[j] - base >= first && rd_cycles[j] - base <= first + 3) cnt++;
      check_eq($sformatf("vec%0d_rd_window", i), cnt, vecs[i].exp_rd_window);
      check_eq($sformatf("vec%0d_last_mask", i), last_mask(), vecs[i].exp_last_mask);
      ok = 0;
      foreach (obs_d[j]) if (j < exp_w.size() && obs_d[j] == exp_w[j]) ok++;
      check_eq($sformatf("vec%0d_data_match", i), ok, vecs[i].nwords);
      check_eq($sformatf("vec%0d_total_reads", i), rd_cycles.size(), vecs[i].nwords);
      step();
      step();
      check_eq($sformatf("vec%0d_idle_after", i), int'(busy), 0);
    end

    // Backpressure: m_ready low for 10 cycles during a burst
    clear_obs();
    exp_w.delete();
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w = WIDTH'($urandom);
      up_q.push_back(w);
      exp_w.push_back(w);
    end
    set_flags();
    repeat (10) step();
    check_eq("bp_reads_during_stall", rd_cycles.size(), 2);
    check_eq("bp_no_output", obs_d.size(), 0);
    check_eq("bp_valid_held", int'(m_valid), 1);
    m_ready = 1'b1;
    t = 0;
    while (obs_d.size() < 4 && t < 50) begin
      step();
      t++;
    end
    check_eq("bp_words_out", obs_d.size(), 4);
    ok = 0;
    foreach (obs_d[j]) if (j < 4 && obs_d[j] == exp_w[j]) ok++;
    check_eq("bp_data_order", ok, 4);
    check_eq("bp_last_mask", last_mask(), 'h08);
    step();
    check_eq("bp_idle_after", int'(busy), 0);

    // Mid-burst empty: 2 words behind an early prog_empty, 2 more 5 cycles later
    clear_obs();
    exp_w.delete();
    m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      w = WIDTH'($urandom);
      up_q.push_back(w);
      exp_w.push_back(w);
    end
    force_prog_low = 1'b1;
    set_flags();
    step();
    force_prog_low = 1'b0;
    set_flags();
    repeat (4) step();
    check_eq("gap_reads_before_refill", rd_cycles.size(), 2);
    check_eq("gap_busy_while_paused", int'(busy), 1);
    for (int k = 0; k < 2; k++) begin
      w = WIDTH'($urandom);
      up_q.push_back(w);
      exp_w.push_back(w);
    end
    set_flags();
    t = 0;
    while (obs_d.size() < 4 && t < 50) begin
      step();
      t++;
    end
    check_eq("gap_words_out", obs_d.size(), 4);
    check_eq("gap_total_reads", rd_cycles.size(), 4);
    ok = 0;
    foreach (obs_d[j]) if (j < 4 && obs_d[j] == exp_w[j]) ok++;
    check_eq("gap_data_order", ok, 4);
    check_eq("gap_last_mask", last_mask(), 'h08);
    step();
    check_eq("gap_idle_after", int'(busy), 0);

    // Reset mid-burst after the 2nd word is accepted
    clear_obs();
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) up_q.push_back(WIDTH'($urandom));
    set_flags();
    t = 0;
    while (obs_d.size() < 2 && t < 30) begin
      step();
      t++;
    end
    check_eq("mrst_two_accepted", obs_d.size(), 2);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mrst");
    up_q.delete();
    outstanding = 0;
    prev_stall  = 1'b0;
    rd_s        = 1'b0;
    set_flags();
    step();
    step();
    rst_n = 1'b1;
    clear_obs();
    valid_cycles = 0;
    repeat (40) step();
    check_eq("mrst_no_stale_valid", valid_cycles, 0);
    check_eq("mrst_no_reads", rd_cycles.size(), 0);
    exp_w.delete();
    for (int k = 0; k < 4; k++) begin
      w = WIDTH'($urandom);
      up_q.push_back(w);
      exp_w.push_back(w);
    end
    set_flags();
    t = 0;
    while (obs_d.size() < 4 && t < 50) begin
      step();
      t++;
    end
    ok = 0;
    foreach (obs_d[j]) if (j < 4 && obs_d[j] == exp_w[j]) ok++;
    check_eq("mrst_fresh_data", ok, 4);
    check_eq("mrst_fresh_last_mask", last_mask(), 'h08);
    step();

    // Random m_ready, 1000 words pushed in groups of four (always full bursts)
    clear_obs();
    exp_w.delete();
    sent = 0;
    t = 0;
    while ((sent < 1000 || obs_d.size() < 1000) && t < 30000) begin
      m_ready = ($urandom_range(0, 99) < 60);
      if (sent < 1000 && up_q.size() <= 12 && $urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 4; k++) begin
          w = WIDTH'($urandom);
          up_q.push_back(w);
          exp_w.push_back(w);
        end
        sent += 4;
      end
      set_flags();
      step();
      t++;
    end
    check_eq("rand_words_out", obs_d.size(), 1000);
    nd = 0;
    nl = 0;
    foreach (obs_d[j]) begin
      if (j >= exp_w.size() || obs_d[j] != exp_w[j]) nd++;
      if (obs_l[j] != ((j % 4) == 3)) nl++;
    end
    check_eq("rand_data_mismatches", nd, 0);
    check_eq("rand_last_mismatches", nl, 0);
    m_ready = 1'b1;
    repeat (3) step();
    check_eq("rand_idle_after", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
